// File: rtl/uart_rx_pkg.sv
// Shared types and frame constants for the UART receiver.
// Imported by the receiver top; the synchronizer stays type-agnostic.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so an idle-high line can come out of reset high.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q two distinct flop stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-byte holding register with
// valid/ready handshake, framing-error and overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_CNT = 434
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CW       = $clog2(BAUD_CNT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 done;
  logic                 bad_stop;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame FSM. done/bad_stop are one-cycle events raised on the stop sample;
  // the output stage turns them into the handshake and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      done     <= 1'b0;
      bad_stop <= 1'b0;
    end else begin
      done     <= 1'b0;
      bad_stop <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            busy     <= 1'b1;
            baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (rx_s) begin
              // Line back high at mid-start: treat the edge as a glitch.
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              // Leaving at mid-stop lets the next start edge follow immediately.
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= ST_BREAK;
              bad_stop <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register. A completed byte replaces the held one only when the
  // consumer is taking it in the same cycle; otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
